// File: rtl/ahb_rambus_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to RamBus bridge.
// State encoding, AHB transfer/response codes and default RamBus widths.
package ahb_rambus_bridge_pkg;

  localparam int RAMBUS_ADDR_W = 10;
  localparam int RAMBUS_DATA_W = 16;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never start a RamBus cycle.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_rambus_bridge_if.sv
// AHB-Lite slave-port signal bundle between the fabric master and the bridge.
// The master modport drives address/control/write data; the slave modport returns the response.
interface ahb_rambus_bridge_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_rambus_bridge.sv
// AHB-Lite responder turning each accepted transfer into one timed RamBus cycle (all outputs registered).
// Data phase lasts STROBE_CYCLES+3 cycles with HREADYOUT low for all but the last; byte writes get a 2-cycle ERROR.
module ahb_rambus_bridge
  import ahb_rambus_bridge_pkg::*;
#(
  parameter int ADDR_W        = RAMBUS_ADDR_W,
  parameter int DATA_W        = RAMBUS_DATA_W,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ahb_rambus_bridge_if.slave    ahb,
  output logic [ADDR_W-1:0]     RamBusAddress,
  output logic [DATA_W-1:0]     RamBusDataOut,
  input  logic [DATA_W-1:0]     RamBusDataIn,
  output logic                  RamBusDataOe,
  output logic                  RamBusnCs,
  output logic                  RamBusWE,
  output logic                  RamBusOE
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_e              state_q,     state_d;
  logic [3:0]          cnt_q,       cnt_d;
  logic                write_q,     write_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   dout_q,      dout_d;
  logic                doe_q,       doe_d;
  logic                ncs_q,       ncs_d;
  logic                we_q,        we_d;
  logic                oe_q,        oe_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q,     hresp_d;
  logic [31:0]         hrdata_q,    hrdata_d;

  logic accept;
  logic is_err;
  logic unused_ok;

  // Only phases seen while we are ready count, so HTRANS churn during wait states is ignored.
  assign accept = hreadyout_q & ahb.HSEL & ahb.HREADY & htrans_active(ahb.HTRANS);
  assign is_err = ahb.HWRITE & (ahb.HSIZE == HSIZE_BYTE);

  assign unused_ok = ^{ahb.HADDR, ahb.HWDATA};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    doe_d       = doe_q;
    ncs_d       = ncs_q;
    we_d        = 1'b0;
    oe_d        = 1'b0;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept && is_err) begin
          state_d     = ST_ERR1;
          ncs_d       = 1'b1;
          doe_d       = 1'b0;
          hreadyout_d = 1'b0;
          hresp_d     = HRESP_ERROR;
        end else if (accept) begin
          state_d     = ST_SETUP;
          addr_d      = ahb.HADDR[ADDR_W+1:2];
          write_d     = ahb.HWRITE;
          ncs_d       = 1'b0;
          doe_d       = ahb.HWRITE;
          hreadyout_d = 1'b0;
          hresp_d     = HRESP_OKAY;
        end else begin
          state_d     = ST_IDLE;
          ncs_d       = 1'b1;
          doe_d       = 1'b0;
          hreadyout_d = 1'b1;
          hresp_d     = HRESP_OKAY;
        end
      end

      ST_SETUP: begin
        // HWDATA is only valid in the data phase, so it is latched here, ahead of WE.
        if (write_q) begin
          dout_d = ahb.HWDATA[DATA_W-1:0];
        end
        state_d = ST_STROBE;
        cnt_d   = STROBE_LAST;
        we_d    = write_q;
        oe_d    = ~write_q;
      end

      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          if (!write_q) begin
            hrdata_d               = '0;
            hrdata_d[DATA_W-1:0]   = RamBusDataIn;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          we_d  = write_q;
          oe_d  = ~write_q;
        end
      end

      ST_HOLD: begin
        state_d     = ST_DONE;
        ncs_d       = 1'b1;
        doe_d       = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end

      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end

      default: begin
        state_d     = ST_IDLE;
        ncs_d       = 1'b1;
        doe_d       = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      ncs_q       <= 1'b1;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      ncs_q       <= ncs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign ahb.HRDATA    = hrdata_q;
  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;

  assign RamBusAddress = addr_q;
  assign RamBusDataOut = dout_q;
  assign RamBusDataOe  = doe_q;
  assign RamBusnCs     = ncs_q;
  assign RamBusWE      = we_q;
  assign RamBusOE      = oe_q;

  a_no_strobe_overlap: assert property (@(posedge clk) disable iff (rst) !(we_q && oe_q));
  a_strobe_needs_cs:   assert property (@(posedge clk) disable iff (rst) (we_q || oe_q) |-> !ncs_q);

endmodule

// File: tb/tb_ahb_rambus_bridge.sv
// Self-checking bench: AHB driver tasks, a RamBus cycle monitor fed by an expectation queue.
module tb_ahb_rambus_bridge;
  import ahb_rambus_bridge_pkg::*;

  localparam int ADDR_W = RAMBUS_ADDR_W;
  localparam int DATA_W = RAMBUS_DATA_W;
  localparam int STROBE = 2;
  localparam logic [63:0] RESET_VEC = {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_rambus_bridge_if bus ();

  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_dout;
  logic [DATA_W-1:0] rb_din;
  logic              rb_doe, rb_ncs, rb_we, rb_oe;

  ahb_rambus_bridge #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .STROBE_CYCLES (STROBE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ahb           (bus.slave),
    .RamBusAddress (rb_addr),
    .RamBusDataOut (rb_dout),
    .RamBusDataIn  (rb_din),
    .RamBusDataOe  (rb_doe),
    .RamBusnCs     (rb_ncs),
    .RamBusWE      (rb_we),
    .RamBusOE      (rb_oe)
  );

  // Single slave on the fabric: the bus ready is our own HREADYOUT.
  assign bus.HREADY = bus.HREADYOUT;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_gap = -1;
  logic [31:0] exp_hrdata = 32'h0;

  function automatic logic [63:0] out_vec();
    return {bus.HREADYOUT, bus.HRESP, bus.HRDATA, rb_ncs, rb_we, rb_oe, rb_doe, rb_addr, rb_dout};
  endfunction

  // RamBus monitor: measures each nCs-low window and compares it against the oldest expectation.
  bit                in_cyc = 1'b0;
  bit                seen_rise = 1'b0;
  int                ncs_len, we_len, oe_len, doe_len, gap_len;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  exp_t              e;

  always @(negedge clk) begin
    if (rst) begin
      in_cyc    = 1'b0;
      seen_rise = 1'b0;
      gap_len   = 0;
    end else begin
      checks++;
      if (rb_we && rb_oe) begin
        errors++;
        $display("FAIL strobe_overlap: WE=%b OE=%b, required not both high", rb_we, rb_oe);
      end
      checks++;
      if ((rb_we || rb_oe) && rb_ncs) begin
        errors++;
        $display("FAIL strobe_without_cs: WE=%b OE=%b nCs=%b, required nCs=0", rb_we, rb_oe, rb_ncs);
      end
      if (!rb_ncs) begin
        if (!in_cyc) begin
          in_cyc   = 1'b1;
          ncs_len  = 0;
          we_len   = 0;
          oe_len   = 0;
          doe_len  = 0;
          cap_addr = rb_addr;
          cap_data = 'x;
          if (seen_rise) last_gap = gap_len;
        end
        ncs_len++;
        if (rb_doe) doe_len++;
        if (rb_oe) oe_len++;
        if (rb_we) begin
          we_len++;
          cap_data = rb_dout;
        end
      end else begin
        if (in_cyc) begin
          in_cyc    = 1'b0;
          seen_rise = 1'b1;
          gap_len   = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cycle: RamBus cycle at addr 0x%0h with no transfer pending", cap_addr);
          end else begin
            e = exp_q.pop_front();
            if (cap_addr !== e.addr) begin
              errors++;
              $display("FAIL rb_addr: got 0x%0h, required 0x%0h", cap_addr, e.addr);
            end
            checks++;
            if (ncs_len != STROBE + 2) begin
              errors++;
              $display("FAIL ncs_len: got %0d, required %0d", ncs_len, STROBE + 2);
            end
            checks++;
            if (e.wr) begin
              if (we_len != STROBE || oe_len != 0 || doe_len != STROBE + 2) begin
                errors++;
                $display("FAIL write_strobes: WE=%0d OE=%0d DataOe=%0d cycles, required %0d/0/%0d",
                         we_len, oe_len, doe_len, STROBE, STROBE + 2);
              end
              checks++;
              if (cap_data !== e.data) begin
                errors++;
                $display("FAIL rb_dout: got 0x%0h, required 0x%0h", cap_data, e.data);
              end
            end else begin
              if (oe_len != STROBE || we_len != 0 || doe_len != 0) begin
                errors++;
                $display("FAIL read_strobes: OE=%0d WE=%0d DataOe=%0d cycles, required %0d/0/0",
                         oe_len, we_len, doe_len, STROBE);
              end
            end
          end
        end
        gap_len++;
      end
    end
  end

  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t x;
    x.wr   = wr;
    x.addr = addr[ADDR_W+1:2];
    x.data = wdata[DATA_W-1:0];
    exp_q.push_back(x);
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input bit push);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    if (push) push_exp(wr, addr, wdata);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (bus.HREADYOUT) break;
      if (i > 50) begin
        checks++;
        errors++;
        $display("FAIL addr_timeout: HREADYOUT=%b for 50 cycles, required 1", bus.HREADYOUT);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic data_phase(input logic [31:0] wdata, input logic [15:0] rdin,
                            input bit nxt, input logic nxt_wr, input logic [31:0] nxt_addr,
                            input logic [31:0] nxt_wdata,
                            output int lows, output logic [31:0] rdata, output logic resp);
    bus.HWDATA = wdata;
    rb_din     = rdin;
    if (nxt) begin
      bus.HSEL   = 1'b1;
      bus.HTRANS = HTRANS_NONSEQ;
      bus.HADDR  = nxt_addr;
      bus.HWRITE = nxt_wr;
      bus.HSIZE  = 3'b010;
      push_exp(nxt_wr, nxt_addr, nxt_wdata);
    end else begin
      bus.HSEL   = 1'b0;
      bus.HTRANS = HTRANS_IDLE;
    end
    lows = 0;
    forever begin
      @(negedge clk);
      if (bus.HREADYOUT) break;
      lows++;
      if (lows > 50) begin
        checks++;
        errors++;
        $display("FAIL data_timeout: HREADYOUT=%b for 50 cycles, required 1", bus.HREADYOUT);
        break;
      end
    end
    rdata = bus.HRDATA;
    resp  = bus.HRESP;
    @(posedge clk);
    #1;
  endtask

  task automatic check_phase(input string name, input int lows, input logic resp, input logic [31:0] rd);
    checks++;
    if (lows != STROBE + 2) begin
      errors++;
      $display("FAIL %s_wait: HREADYOUT low %0d cycles, required %0d", name, lows, STROBE + 2);
    end
    checks++;
    if (resp !== HRESP_OKAY) begin
      errors++;
      $display("FAIL %s_resp: HRESP=%b, required 0", name, resp);
    end
    checks++;
    if (rd !== exp_hrdata) begin
      errors++;
      $display("FAIL %s_hrdata: got 0x%08h, required 0x%08h", name, rd, exp_hrdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got 0x%016h, required 0x%016h", out_vec(), RESET_VEC);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write();
    int lows; logic [31:0] rd; logic resp;
    addr_phase(1'b1, 32'h0000_0010, 3'b010, 32'h0000_BEEF, 1'b1);
    data_phase(32'h0000_BEEF, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0, lows, rd, resp);
    check_phase("write", lows, resp, rd);
  endtask

  task automatic test_read();
    int lows; logic [31:0] rd; logic resp;
    addr_phase(1'b0, 32'h0000_0FFC, 3'b010, 32'h0, 1'b1);
    exp_hrdata = 32'h0000_1234;
    data_phase(32'h0, 16'h1234, 1'b0, 1'b0, 32'h0, 32'h0, lows, rd, resp);
    check_phase("read", lows, resp, rd);
  endtask

  task automatic test_back_to_back();
    int lows; logic [31:0] rd; logic resp;
    last_gap = -1;
    addr_phase(1'b1, 32'h0000_0020, 3'b010, 32'h0000_A5A5, 1'b1);
    data_phase(32'h0000_A5A5, 16'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, lows, rd, resp);
    check_phase("b2b_wr", lows, resp, rd);
    exp_hrdata = 32'h0000_5A5A;
    data_phase(32'h0, 16'h5A5A, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_C3C3, lows, rd, resp);
    check_phase("b2b_rd", lows, resp, rd);
    checks++;
    if (last_gap != 1) begin
      errors++;
      $display("FAIL b2b_gap1: nCs high %0d cycles, required 1", last_gap);
    end
    data_phase(32'h0000_C3C3, 16'hFFFF, 1'b0, 1'b0, 32'h0, 32'h0, lows, rd, resp);
    check_phase("b2b_wr2", lows, resp, rd);
    checks++;
    if (last_gap != 1) begin
      errors++;
      $display("FAIL b2b_gap2: nCs high %0d cycles, required 1", last_gap);
    end
  endtask

  task automatic test_error();
    int lows; logic [31:0] rd; logic resp;
    logic [2:0] want [3];
    want[0] = 3'b011;
    want[1] = 3'b111;
    want[2] = 3'b101;
    addr_phase(1'b1, 32'h0000_0050, HSIZE_BYTE, 32'h0, 1'b0);
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, rb_ncs} !== want[i]) begin
        errors++;
        $display("FAIL err_cycle%0d: {HREADYOUT,HRESP,nCs}=%b, required %b",
                 i, {bus.HREADYOUT, bus.HRESP, rb_ncs}, want[i]);
      end
    end
    @(posedge clk);
    #1;
    addr_phase(1'b1, 32'h0000_0052, 3'b001, 32'h0000_7777, 1'b1);
    data_phase(32'h0000_7777, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0, lows, rd, resp);
    check_phase("post_err_wr", lows, resp, rd);
  endtask

  task automatic test_idle_busy();
    bus.HWRITE = 1'b1;
    bus.HADDR  = 32'h0000_0060;
    bus.HSIZE  = 3'b010;
    for (int i = 0; i < 8; i++) begin
      bus.HSEL   = (i < 6);
      bus.HTRANS = (i < 3) ? HTRANS_IDLE : (i < 6) ? HTRANS_BUSY : HTRANS_NONSEQ;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, rb_ncs} !== 3'b101) begin
        errors++;
        $display("FAIL idle_busy%0d: {HREADYOUT,HRESP,nCs}=%b, required 101",
                 i, {bus.HREADYOUT, bus.HRESP, rb_ncs});
      end
    end
    bus.HTRANS = HTRANS_IDLE;
    bus.HSEL   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lows; logic [31:0] rd; logic resp;
    addr_phase(1'b1, 32'h0000_0030, 3'b010, 32'h0000_1111, 1'b1);
    bus.HWDATA = 32'h0000_1111;
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (rb_we) break;
      if (i > 20) begin
        checks++;
        errors++;
        $display("FAIL rst_mid_we_timeout: WE=%b for 20 cycles, required 1", rb_we);
        break;
      end
    end
    #1 rst = 1'b1;
    exp_q.delete();
    exp_hrdata = 32'h0;
    @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL rst_mid_outputs: got 0x%016h, required 0x%016h", out_vec(), RESET_VEC);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    addr_phase(1'b0, 32'h0000_0008, 3'b010, 32'h0, 1'b1);
    exp_hrdata = 32'h0000_0F0F;
    data_phase(32'h0, 16'h0F0F, 1'b0, 1'b0, 32'h0, 32'h0, lows, rd, resp);
    check_phase("rst_mid_rd", lows, resp, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.HSEL   = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = 32'h0;
    rb_din     = '0;

    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_error();
    test_idle_busy();
    test_reset_mid();

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d cycles still pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
